// File: rtl/compare_search_ctrl.sv
// Binary-search initiator: probes an external magnitude comparator to locate an unknown target.
// Latency: one clock per probe when iCmpValid is tied high; new probe appears the cycle after a consumed result.
// Backpressure: oProbe is held stable until iCmpValid; optional abort via SEARCH_TIMEOUT_EN (wait counter, TIMEOUT cycles).
module compare_search_ctrl #(
    parameter int WIDTH   = 8,
    parameter int TIMEOUT = 16
) (
    input  logic                          iClk,
    input  logic                          iRst,
    input  logic                          iStart,
    output logic [WIDTH-1:0]              oProbe,
    output logic                          oProbeValid,
    input  logic [2:0]                    iCmp,
    input  logic                          iCmpValid,
    output logic                          oBusy,
    output logic                          oDone,
    output logic                          oFound,
    output logic                          oErr,
    output logic [WIDTH-1:0]              oResult,
    output logic [$clog2(WIDTH+2)-1:0]    oIters
);

    localparam int ITER_W = $clog2(WIDTH + 2);

    localparam logic [2:0] CMP_GT = 3'b100;   // probe > target
    localparam logic [2:0] CMP_LT = 3'b010;   // probe < target
    localparam logic [2:0] CMP_EQ = 3'b001;   // probe == target

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PROBE = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t              state_q,  state_d;
    logic [WIDTH-1:0]    lo_q,     lo_d;
    logic [WIDTH-1:0]    hi_q,     hi_d;
    logic [WIDTH-1:0]    probe_q,  probe_d;
    logic                pvld_q,   pvld_d;
    logic                busy_q,   busy_d;
    logic                done_q,   done_d;
    logic                found_q,  found_d;
    logic                err_q,    err_d;
    logic [WIDTH-1:0]    result_q, result_d;
    logic [ITER_W-1:0]   iters_q,  iters_d;

`ifdef SEARCH_TIMEOUT_EN
    localparam int WAIT_W = $clog2(TIMEOUT + 1);
    logic [WAIT_W-1:0]   wait_q,   wait_d;
`else
    // TIMEOUT only matters when the wait counter is built in.
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT != 0);
`endif

    // Midpoint of [lo, hi]; the sum is formed one bit wider, and since hi >= lo it always fits back in WIDTH.
    function automatic logic [WIDTH-1:0] mid_of(input logic [WIDTH-1:0] lo, input logic [WIDTH-1:0] hi);
        mid_of = WIDTH'({1'b0, lo} + (({1'b0, hi} - {1'b0, lo}) >> 1));
    endfunction

    // Next-state and registered-output logic for the search FSM.
    always_comb begin
        state_d  = state_q;
        lo_d     = lo_q;
        hi_d     = hi_q;
        probe_d  = probe_q;
        pvld_d   = pvld_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        found_d  = found_q;
        err_d    = err_q;
        result_d = result_q;
        iters_d  = iters_q;
`ifdef SEARCH_TIMEOUT_EN
        wait_d   = wait_q;
`endif

        case (state_q)
            ST_IDLE: begin
                pvld_d = 1'b0;
                busy_d = 1'b0;
                if (iStart) begin
                    lo_d     = '0;
                    hi_d     = '1;
                    probe_d  = mid_of('0, '1);
                    pvld_d   = 1'b1;
                    busy_d   = 1'b1;
                    iters_d  = '0;
                    found_d  = 1'b0;
                    err_d    = 1'b0;
                    result_d = '0;
`ifdef SEARCH_TIMEOUT_EN
                    wait_d   = '0;
`endif
                    state_d  = ST_PROBE;
                end
            end

            ST_PROBE: begin
                if (iCmpValid) begin
                    iters_d = iters_q + ITER_W'(1);
`ifdef SEARCH_TIMEOUT_EN
                    wait_d  = '0;
`endif
                    case (iCmp)
                        CMP_EQ: begin
                            found_d  = 1'b1;
                            result_d = probe_q;
                            state_d  = ST_DONE;
                        end
                        CMP_GT: begin
                            // Range exhausted on the low side: mid-1 would underflow lo.
                            if (probe_q == lo_q) begin
                                state_d = ST_DONE;
                            end else begin
                                hi_d    = probe_q - WIDTH'(1);
                                probe_d = mid_of(lo_q, probe_q - WIDTH'(1));
                            end
                        end
                        CMP_LT: begin
                            // Range exhausted on the high side: mid+1 would overflow hi.
                            if (probe_q == hi_q) begin
                                state_d = ST_DONE;
                            end else begin
                                lo_d    = probe_q + WIDTH'(1);
                                probe_d = mid_of(probe_q + WIDTH'(1), hi_q);
                            end
                        end
                        default: begin
                            err_d   = 1'b1;
                            state_d = ST_DONE;
                        end
                    endcase
                end
`ifdef SEARCH_TIMEOUT_EN
                else begin
                    wait_d = wait_q + WAIT_W'(1);
                    // Last tolerated idle cycle: give up on the responder.
                    if (wait_q == WAIT_W'(TIMEOUT - 1)) begin
                        err_d   = 1'b1;
                        found_d = 1'b0;
                        state_d = ST_DONE;
                    end
                end
`endif
                if (state_d == ST_DONE) begin
                    pvld_d = 1'b0;
                    busy_d = 1'b0;
                    done_d = 1'b1;
                end
            end

            ST_DONE: begin
                pvld_d  = 1'b0;
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end

            default: begin
                pvld_d  = 1'b0;
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset aborts any search in progress.
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            state_q  <= ST_IDLE;
            lo_q     <= '0;
            hi_q     <= '1;
            probe_q  <= '0;
            pvld_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            found_q  <= 1'b0;
            err_q    <= 1'b0;
            result_q <= '0;
            iters_q  <= '0;
`ifdef SEARCH_TIMEOUT_EN
            wait_q   <= '0;
`endif
        end else begin
            state_q  <= state_d;
            lo_q     <= lo_d;
            hi_q     <= hi_d;
            probe_q  <= probe_d;
            pvld_q   <= pvld_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            found_q  <= found_d;
            err_q    <= err_d;
            result_q <= result_d;
            iters_q  <= iters_d;
`ifdef SEARCH_TIMEOUT_EN
            wait_q   <= wait_d;
`endif
        end
    end

    assign oProbe      = probe_q;
    assign oProbeValid = pvld_q;
    assign oBusy       = busy_q;
    assign oDone       = done_q;
    assign oFound      = found_q;
    assign oErr        = err_q;
    assign oResult     = result_q;
    assign oIters      = iters_q;

endmodule

// File: tb/tb_compare_search_ctrl.sv
// Directed bench for compare_search_ctrl (WIDTH=8) with a behavioural comparator responder.
// Latency: responder answers combinationally from oProbe; iCmpValid is paced by the driving task.
// Backpressure: tasks may hold iCmpValid low to stall the searcher.
module tb_compare_search_ctrl;

    typedef logic [7:0] seq_t [9];

    logic       iClk = 1'b0;
    logic       iRst;
    logic       iStart;
    logic [7:0] oProbe;
    logic       oProbeValid;
    logic [2:0] iCmp;
    logic       iCmpValid;
    logic       oBusy;
    logic       oDone;
    logic       oFound;
    logic       oErr;
    logic [7:0] oResult;
    logic [3:0] oIters;

    logic [7:0] target;
    logic       force_en;
    logic [2:0] force_code;

    int checks = 0;
    int errors = 0;

    logic [7:0] probes [$];
    int         stable_bad;
    int         pv_cycles;
    bit         done_seen;

    seq_t seq_5a, seq_ff, seq_00;

    compare_search_ctrl #(.WIDTH(8), .TIMEOUT(16)) dut (
        .iClk        (iClk),
        .iRst        (iRst),
        .iStart      (iStart),
        .oProbe      (oProbe),
        .oProbeValid (oProbeValid),
        .iCmp        (iCmp),
        .iCmpValid   (iCmpValid),
        .oBusy       (oBusy),
        .oDone       (oDone),
        .oFound      (oFound),
        .oErr        (oErr),
        .oResult     (oResult),
        .oIters      (oIters)
    );

    always #5 iClk = ~iClk;

    // Reference comparator, optionally overridden with a fixed code.
    assign iCmp = force_en ? force_code :
                  (oProbe > target) ? 3'b100 :
                  (oProbe < target) ? 3'b010 : 3'b001;

    // Starts a search and services probes; each probe waits `delay` cycles with iCmpValid low.
    task automatic run_search(input int delay, input int max_cycles, input int poke_at);
        logic [7:0] held;
        int         wcnt;
        held       = '0;
        wcnt       = 0;
        probes.delete();
        stable_bad = 0;
        pv_cycles  = 0;
        done_seen  = 0;
        @(negedge iClk);
        iCmpValid = (delay == 0);
        iStart    = 1'b1;
        for (int c = 0; c < max_cycles && !done_seen; c++) begin
            @(negedge iClk);
            iStart = (c == poke_at);
            if (oDone) begin
                done_seen = 1;
            end else if (oProbeValid) begin
                pv_cycles++;
                if (wcnt < delay) begin
                    if (wcnt > 0 && oProbe !== held) stable_bad++;
                    held      = oProbe;
                    iCmpValid = 1'b0;
                    wcnt++;
                end else begin
                    if (delay > 0 && oProbe !== held) stable_bad++;
                    iCmpValid = 1'b1;
                    probes.push_back(oProbe);
                    wcnt = 0;
                end
            end
        end
        iStart = 1'b0;
    endtask

    task automatic test_reset();
        iRst = 1'b1; iStart = 1'b0; iCmpValid = 1'b0;
        force_en = 1'b0; force_code = 3'b000; target = 8'h00;
        #12;
        checks++; if (oProbe !== 8'h00)   begin $display("FAIL reset_probe got=%h exp=00", oProbe); errors++; end
        checks++; if ({oProbeValid, oBusy, oDone, oFound, oErr} !== 5'b0)
            begin $display("FAIL reset_flags got=%b exp=00000", {oProbeValid, oBusy, oDone, oFound, oErr}); errors++; end
        checks++; if (oResult !== 8'h00)  begin $display("FAIL reset_result got=%h exp=00", oResult); errors++; end
        checks++; if (oIters !== 4'd0)    begin $display("FAIL reset_iters got=%0d exp=0", oIters); errors++; end
        @(negedge iClk); iRst = 1'b0;
        @(negedge iClk);
        checks++; if (oBusy !== 1'b0)     begin $display("FAIL reset_idle_busy got=%b exp=0", oBusy); errors++; end
    endtask

    task automatic test_hit(input string name, input logic [7:0] tgt, input int n, input seq_t exp);
        logic [7:0] got;
        target = tgt; force_en = 1'b0;
        run_search(0, 40, -1);
        checks++; if (!done_seen) begin $display("FAIL %s_done_seen got=0 exp=1", name); errors++; end
        checks++; if (oBusy !== 1'b0) begin $display("FAIL %s_busy_in_done got=%b exp=0", name, oBusy); errors++; end
        checks++; if (probes.size() != n) begin $display("FAIL %s_probe_count got=%0d exp=%0d", name, probes.size(), n); errors++; end
        for (int i = 0; i < n; i++) begin
            got = (i < probes.size()) ? probes[i] : 8'hxx;
            checks++; if (got !== exp[i]) begin $display("FAIL %s_probe%0d got=%h exp=%h", name, i, got, exp[i]); errors++; end
        end
        checks++; if (oFound !== 1'b1) begin $display("FAIL %s_found got=%b exp=1", name, oFound); errors++; end
        checks++; if (oErr !== 1'b0) begin $display("FAIL %s_err got=%b exp=0", name, oErr); errors++; end
        checks++; if (oResult !== tgt) begin $display("FAIL %s_result got=%h exp=%h", name, oResult, tgt); errors++; end
        checks++; if (oIters !== 4'(n)) begin $display("FAIL %s_iters got=%0d exp=%0d", name, oIters, n); errors++; end
        @(negedge iClk);
        checks++; if (oDone !== 1'b0) begin $display("FAIL %s_done_pulse got=%b exp=0", name, oDone); errors++; end
        checks++; if (oResult !== tgt) begin $display("FAIL %s_result_held got=%h exp=%h", name, oResult, tgt); errors++; end
    endtask

    task automatic test_not_found();
        force_en = 1'b1; force_code = 3'b010;
        run_search(0, 40, -1);
        checks++; if (!done_seen) begin $display("FAIL nf_done_seen got=0 exp=1"); errors++; end
        checks++; if (probes.size() != 9 || probes[probes.size()-1] !== 8'hFF)
            begin $display("FAIL nf_last_probe count=%0d exp 9 probes ending FF", probes.size()); errors++; end
        checks++; if ({oFound, oErr} !== 2'b00) begin $display("FAIL nf_flags got=%b exp=00", {oFound, oErr}); errors++; end
        checks++; if (oIters !== 4'd9) begin $display("FAIL nf_iters got=%0d exp=9", oIters); errors++; end
        checks++; if (oResult !== 8'h00) begin $display("FAIL nf_result got=%h exp=00", oResult); errors++; end
        force_en = 1'b0;
        @(negedge iClk);
    endtask

    task automatic test_illegal_code();
        force_en = 1'b1; force_code = 3'b011;
        run_search(0, 10, -1);
        checks++; if (!done_seen) begin $display("FAIL ill_done_seen got=0 exp=1"); errors++; end
        checks++; if ({oFound, oErr} !== 2'b01) begin $display("FAIL ill_flags got=%b exp=01", {oFound, oErr}); errors++; end
        checks++; if (oIters !== 4'd1) begin $display("FAIL ill_iters got=%0d exp=1", oIters); errors++; end
        force_en = 1'b0;
        @(negedge iClk);
        checks++; if (oDone !== 1'b0) begin $display("FAIL ill_done_pulse got=%b exp=0", oDone); errors++; end
        checks++; if (oErr !== 1'b1) begin $display("FAIL ill_err_held got=%b exp=1", oErr); errors++; end
    endtask

    task automatic test_start_while_busy();
        target = 8'h5A; force_en = 1'b0;
        run_search(0, 40, 2);
        checks++; if (probes.size() != 8) begin $display("FAIL busy_probe_count got=%0d exp=8", probes.size()); errors++; end
        checks++; if ({oFound, oResult, oIters} !== {1'b1, 8'h5A, 4'd8})
            begin $display("FAIL busy_result got=%b/%h/%0d exp=1/5a/8", oFound, oResult, oIters); errors++; end
        @(negedge iClk); @(negedge iClk);
        checks++; if ({oBusy, oProbeValid} !== 2'b00) begin $display("FAIL busy_no_restart got=%b exp=00", {oBusy, oProbeValid}); errors++; end
    endtask

    task automatic test_delayed_valid();
        target = 8'h5A; force_en = 1'b0;
        run_search(3, 80, -1);
        checks++; if (stable_bad != 0) begin $display("FAIL dly_probe_stable got=%0d exp=0", stable_bad); errors++; end
        checks++; if (pv_cycles != 32) begin $display("FAIL dly_probe_cycles got=%0d exp=32", pv_cycles); errors++; end
        checks++; if (probes.size() != 8 || probes[7] !== 8'h5A || probes[0] !== 8'h7F)
            begin $display("FAIL dly_probe_seq count=%0d exp 8 probes 7f..5a", probes.size()); errors++; end
        checks++; if ({oFound, oErr, oResult, oIters} !== {1'b1, 1'b0, 8'h5A, 4'd8})
            begin $display("FAIL dly_result got=%b/%b/%h/%0d exp=1/0/5a/8", oFound, oErr, oResult, oIters); errors++; end
        @(negedge iClk);
    endtask

    task automatic test_no_valid();
        target = 8'h5A; force_en = 1'b0;
`ifdef SEARCH_TIMEOUT_EN
        run_search(1000, 40, -1);
        checks++; if (!done_seen) begin $display("FAIL to_done_seen got=0 exp=1"); errors++; end
        checks++; if (pv_cycles != 16) begin $display("FAIL to_probe_cycles got=%0d exp=16", pv_cycles); errors++; end
        checks++; if ({oFound, oErr} !== 2'b01) begin $display("FAIL to_flags got=%b exp=01", {oFound, oErr}); errors++; end
        checks++; if (oIters !== 4'd0) begin $display("FAIL to_iters got=%0d exp=0", oIters); errors++; end
        @(negedge iClk);
`else
        run_search(1000, 40, -1);
        checks++; if (done_seen) begin $display("FAIL wait_done_seen got=1 exp=0"); errors++; end
        checks++; if (oProbe !== 8'h7F || stable_bad != 0)
            begin $display("FAIL wait_probe_hold got=%h unstable=%0d exp=7f/0", oProbe, stable_bad); errors++; end
        iCmpValid = 1'b1;
        done_seen = 0;
        for (int c = 0; c < 20 && !done_seen; c++) begin
            @(negedge iClk);
            if (oDone) done_seen = 1;
        end
        checks++; if (!done_seen) begin $display("FAIL wait_resume_done got=0 exp=1"); errors++; end
        checks++; if ({oFound, oResult, oIters} !== {1'b1, 8'h5A, 4'd8})
            begin $display("FAIL wait_resume_result got=%b/%h/%0d exp=1/5a/8", oFound, oResult, oIters); errors++; end
        @(negedge iClk);
`endif
    endtask

    task automatic test_reset_mid_search();
        target = 8'h5A; force_en = 1'b0;
        run_search(1000, 5, -1);
        checks++; if (oBusy !== 1'b1) begin $display("FAIL rst_mid_busy_before got=%b exp=1", oBusy); errors++; end
        #2 iRst = 1'b1;
        #1;
        checks++; if ({oProbe, oProbeValid, oBusy, oDone, oFound, oErr, oResult, oIters} !== 29'b0)
            begin $display("FAIL rst_mid_outputs got=%h/%b%b%b%b%b/%h/%0d exp=all zero", oProbe, oProbeValid, oBusy, oDone, oFound, oErr, oResult, oIters); errors++; end
        @(negedge iClk); iRst = 1'b0;
        @(negedge iClk);
        checks++; if ({oBusy, oProbeValid} !== 2'b00) begin $display("FAIL rst_mid_idle got=%b exp=00", {oBusy, oProbeValid}); errors++; end
    endtask

    initial begin
        seq_5a = '{8'h7F, 8'h3F, 8'h5F, 8'h4F, 8'h57, 8'h5B, 8'h59, 8'h5A, 8'h00};
        seq_ff = '{8'h7F, 8'hBF, 8'hDF, 8'hEF, 8'hF7, 8'hFB, 8'hFD, 8'hFE, 8'hFF};
        seq_00 = '{8'h7F, 8'h3F, 8'h1F, 8'h0F, 8'h07, 8'h03, 8'h01, 8'h00, 8'h00};

        test_reset();
        test_hit("t5a", 8'h5A, 8, seq_5a);
        test_hit("tff", 8'hFF, 9, seq_ff);
        test_hit("t00", 8'h00, 8, seq_00);
        test_not_found();
        test_illegal_code();
        test_start_while_busy();
        test_delayed_valid();
        test_no_valid();
        test_reset_mid_search();
        test_hit("post_rst", 8'h5A, 8, seq_5a);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not complete within time budget");
        $fatal(1, "watchdog");
    end

endmodule
